// File: rtl/instr_read_sequencer_if.sv
// Shared instr_register types and the output word stream
// between the read sequencer and its consumer.
package instr_read_sequencer_pkg;
    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t            opc;
        operand_t           op_a;
        operand_t           op_b;
        logic signed [63:0] rezultat;
    } instruction_t;
endpackage

interface instr_read_sequencer_if;
    import instr_read_sequencer_pkg::*;

    logic         out_valid;
    logic         out_ready;
    address_t     out_addr;
    instruction_t out_word;

    modport master (
        output out_valid,
        output out_addr,
        output out_word,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_word,
        output out_ready
    );
endinterface

// File: rtl/instr_read_sequencer.sv
// Walks instr_register in increasing, decreasing or LFSR order
// and streams each captured word out on a valid/ready channel.
module instr_read_sequencer
    import instr_read_sequencer_pkg::*;
#(
    parameter int       CNT_W          = 6,
    parameter address_t LFSR_ZERO_SEED = 5'h01
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  address_t            first_addr,
    input  logic [CNT_W-1:0]    count,
    input  logic [1:0]          order,
    output address_t            read_pointer,
    input  instruction_t        instruction_word,
    instr_read_sequencer_if.master out_if,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    words_sent
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t       state_q, state_d;
    address_t     rp_q, rp_d, rp_nxt;
    address_t     addr_q, addr_d;
    instruction_t word_q, word_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [1:0]   ord_q, ord_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] iss_q, iss_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W:0]   iss_inc;
    logic         adv;
    logic         acc;

    assign adv     = !valid_q || out_if.out_ready;
    assign acc     = valid_q && out_if.out_ready;
    assign iss_inc = {1'b0, iss_q} + (CNT_W+1)'(1);

    // In LFSR order read_pointer is itself the LFSR state
    always_comb begin
        rp_nxt = rp_q + 5'd1;
        unique case (1'b1)
            ord_q == 2'd2: rp_nxt = rp_q - 5'd1;
            ord_q == 2'd3: rp_nxt = {rp_q[3:0], rp_q[4] ^ rp_q[2]};
            default:       rp_nxt = rp_q + 5'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        addr_d  = addr_q;
        word_d  = word_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ord_d   = ord_q;
        cnt_d   = cnt_q;
        iss_d   = iss_q;
        sent_d  = sent_q;
        if (acc)
            sent_d = sent_q + CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (start && count != '0) begin
                    state_d = RUN;
                    cnt_d   = count;
                    ord_d   = (order == 2'd0) ? 2'd1 : order;
                    rp_d    = (order == 2'd3 && first_addr == '0)
                              ? LFSR_ZERO_SEED : first_addr;
                    busy_d  = 1'b1;
                    sent_d  = '0;
                    iss_d   = '0;
                end
            end
            RUN: begin
                if (adv) begin
                    word_d  = instruction_word;
                    addr_d  = rp_q;
                    valid_d = 1'b1;
                    iss_d   = iss_q + CNT_W'(1);
                    if (iss_inc < {1'b0, cnt_q})
                        rp_d = rp_nxt;
                    else
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (acc) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rp_q    <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ord_q   <= 2'd1;
            cnt_q   <= '0;
            iss_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
            iss_q   <= iss_d;
            sent_q  <= sent_d;
        end
    end

    assign read_pointer     = rp_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_word  = word_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign words_sent       = sent_q;

endmodule

// File: tb/tb_instr_read_sequencer.sv
// Scoreboard bench for instr_read_sequencer with a behavioural
// instr_register model driving instruction_word.
module tb_instr_read_sequencer;
    import instr_read_sequencer_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    logic [1:0]   order;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         busy;
    logic         done;
    logic [5:0]   words_sent;

    instr_read_sequencer_if ifc ();

    instr_read_sequencer #(
        .CNT_W          (6),
        .LFSR_ZERO_SEED (5'h01)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .order            (order),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_if           (ifc.master),
        .busy             (busy),
        .done             (done),
        .words_sent       (words_sent)
    );

    instruction_t mem [32];
    address_t     exp_q [$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           done_cnt = 0;

    always_comb instruction_word = mem[read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input address_t a);
        exp_q.push_back(a);
    endtask

    task automatic issue(input address_t fa, input logic [5:0] c,
                         input logic [1:0] o);
        start      = 1'b1;
        first_addr = fa;
        count      = c;
        order      = o;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc, output int fv);
        cyc = 0;
        fv  = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (fv == 0 && ifc.out_valid) fv = cyc;
            if (done) break;
            if (cyc >= bound) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_timeout: got no done expected done within %0d", bound);
                break;
            end
        end
    endtask

    // Monitor: pops one expectation per accepted word, checks stall stability
    logic         hold;
    address_t     h_addr;
    address_t     h_rp;
    instruction_t h_word;
    initial begin
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!reset_n) begin
                hold = 1'b0;
            end else if (ifc.out_valid) begin
                if (hold) begin
                    chk("stall_addr", 160'(ifc.out_addr), 160'(h_addr));
                    chk("stall_word", 160'(ifc.out_word), 160'(h_word));
                    chk("stall_rp", 160'(read_pointer), 160'(h_rp));
                end
                if (ifc.out_ready) begin
                    hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got addr %0h expected none",
                                 ifc.out_addr);
                    end else begin
                        address_t a;
                        a = exp_q.pop_front();
                        chk("out_addr", 160'(ifc.out_addr), 160'(a));
                        chk("out_word", 160'(ifc.out_word), 160'(mem[a]));
                    end
                end else begin
                    hold   = 1'b1;
                    h_addr = ifc.out_addr;
                    h_word = ifc.out_word;
                    h_rp   = read_pointer;
                end
            end
        end
    end

    initial begin
        int cyc, fv, d0;
        for (int i = 0; i < 32; i++) begin
            mem[i].opc      = opcode_t'(i % 8);
            mem[i].op_a     = 32'(i * 7 + 3);
            mem[i].op_b     = -32'(i);
            mem[i].rezultat = {32'(i), 32'hA5A5_0000 | 32'(i)};
        end
        reset_n       = 1'b0;
        start         = 1'b0;
        first_addr    = '0;
        count         = '0;
        order         = 2'd1;
        ifc.out_ready = 1'b1;
        #2;
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_valid", 160'(ifc.out_valid), 160'(0));
        chk("rst_rp", 160'(read_pointer), 160'(0));
        chk("rst_sent", 160'(words_sent), 160'(0));
        chk("rst_word", 160'(ifc.out_word), 160'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // increasing from 0
        push(0); push(1); push(2); push(3);
        d0 = done_cnt;
        issue(5'd0, 6'd4, 2'd1);
        wait_done(40, cyc, fv);
        chk("inc_first_valid", 160'(fv), 160'(1));
        chk("inc_latency", 160'(cyc), 160'(5));
        chk("inc_sent", 160'(words_sent), 160'(4));
        @(posedge clk); #1;
        chk("inc_done_low", 160'(done), 160'(0));
        chk("inc_done_once", 160'(done_cnt - d0), 160'(1));
        chk("inc_busy", 160'(busy), 160'(0));

        // decreasing with 0 -> 31 wrap
        push(1); push(0); push(31);
        d0 = done_cnt;
        issue(5'd1, 6'd3, 2'd2);
        wait_done(40, cyc, fv);
        chk("dec_latency", 160'(cyc), 160'(4));
        @(posedge clk); #1;
        chk("dec_done_once", 160'(done_cnt - d0), 160'(1));
        chk("dec_busy", 160'(busy), 160'(0));
        chk("dec_sent", 160'(words_sent), 160'(3));

        // backpressure for 3 cycles after the first valid
        push(5); push(6); push(7);
        issue(5'd5, 6'd3, 2'd1);
        @(posedge clk); #1;
        chk("bp_first_valid", 160'(ifc.out_valid), 160'(1));
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rp_held", 160'(read_pointer), 160'(6));
        ifc.out_ready = 1'b1;
        wait_done(40, cyc, fv);
        chk("bp_sent", 160'(words_sent), 160'(3));

        // LFSR from zero seed
        push(1); push(2); push(4); push(9); push(18); push(5);
        issue(5'd0, 6'd6, 2'd3);
        wait_done(40, cyc, fv);
        chk("lfsr_latency", 160'(cyc), 160'(7));
        chk("lfsr_sent", 160'(words_sent), 160'(6));

        // count=0 request is ignored
        issue(5'd3, 6'd0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            chk("zero_busy", 160'(busy), 160'(0));
            chk("zero_valid", 160'(ifc.out_valid), 160'(0));
            @(posedge clk); #1;
        end

        // start during RUN is ignored
        push(10); push(11); push(12); push(13);
        issue(5'd10, 6'd4, 2'd1);
        @(posedge clk); #1;
        issue(5'd20, 6'd2, 2'd2);
        wait_done(40, cyc, fv);
        chk("run_start_sent", 160'(words_sent), 160'(4));
        @(posedge clk); #1;

        // order 0 behaves as increasing, with 31 -> 0 wrap
        push(30); push(31); push(0);
        issue(5'd30, 6'd3, 2'd0);
        wait_done(40, cyc, fv);
        chk("ord0_sent", 160'(words_sent), 160'(3));
        @(posedge clk); #1;

        // reset after the 4th accepted word
        for (int i = 8; i < 18; i++) push(address_t'(i));
        issue(5'd8, 6'd10, 2'd1);
        cyc = 0;
        while (words_sent != 6'd4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_reach4", 160'(words_sent), 160'(4));
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_busy", 160'(busy), 160'(0));
        chk("mid_valid", 160'(ifc.out_valid), 160'(0));
        chk("mid_done", 160'(done), 160'(0));
        chk("mid_rp", 160'(read_pointer), 160'(0));
        chk("mid_addr", 160'(ifc.out_addr), 160'(0));
        chk("mid_word", 160'(ifc.out_word), 160'(0));
        chk("mid_sent", 160'(words_sent), 160'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_no_done", 160'(done_cnt - d0), 160'(0));

        for (int i = 8; i < 18; i++) push(address_t'(i));
        issue(5'd8, 6'd10, 2'd1);
        wait_done(60, cyc, fv);
        chk("rerun_latency", 160'(cyc), 160'(11));
        chk("rerun_sent", 160'(words_sent), 160'(10));
        @(posedge clk); #1;
        chk("sb_empty", 160'(exp_q.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_read_sequencer.md
Name: instr_read_sequencer

Overview:
- Downstream stage of instr_register. Drives its read_pointer, samples the combinational instruction_word, and streams each word out on a valid/ready interface.
- Supports increasing, decreasing and pseudo-random address orders, so the readback loop moves out of the bench into RTL.
- Sits between instr_register and the result checker / scoreboard.

Parameters:
- CNT_W, 6, width of count input and words_sent counter (max burst 63 words).
- LFSR_ZERO_SEED, 5'h01, seed substituted when order=3 and first_addr=0.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- first_addr  input  address_t (5)  first location read.
- count  input  CNT_W  number of words to read; 0 = request ignored.
- order  input  2  1 = increasing, 2 = decreasing, 3 = LFSR, 0 = treated as 1.
- read_pointer  output  address_t (5)  to instr_register.read_pointer.
- instruction_word  input  instruction_t  from instr_register; combinational function of read_pointer.
- out_valid  output  1  out_word/out_addr valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a clock edge.
- out_addr  output  address_t  address the word was read from.
- out_word  output  instruction_t  captured {opc, op_a, op_b, rezultat}.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last word is accepted.
- words_sent  output  CNT_W  accepted words in the current or last burst.

Behaviour:
- Reset, async, any state: state=IDLE, read_pointer=5'h00, out_valid=0, out_addr=0, out_word='{opc:ZERO, default:0}, busy=0, done=0, words_sent=0, internal issue counter=0.
- Reset mid-burst aborts the burst immediately. No done pulse; the partial burst is lost.
- FSM states: IDLE, RUN, DRAIN.
- IDLE to RUN at edge E0 when start=1 and count!=0.
  - Latch count and order.
  - read_pointer <= first_addr. For order 3, the LFSR is seeded with first_addr, or LFSR_ZERO_SEED if first_addr=0.
  - busy <= 1, words_sent <= 0, issued <= 0.
- start with count=0, or start outside IDLE: ignored, no state change.
- RUN, advance condition adv = !out_valid || out_ready. When adv is true:
  - out_word <= instruction_word, out_addr <= read_pointer, out_valid <= 1, issued++.
  - If issued+1 < count, read_pointer <= next address. Otherwise read_pointer holds and state goes to DRAIN.
- RUN, adv false (backpressure): read_pointer, out_word, out_addr and out_valid all hold. No word is lost or duplicated.
- words_sent increments on every edge with out_valid && out_ready, in RUN and DRAIN.
- DRAIN: on out_valid && out_ready, out_valid <= 0, busy <= 0, done <= 1 for one cycle, state goes to IDLE.
- Next address:
  - order 1: +1 mod 32 (31 wraps to 0).
  - order 2: -1 mod 32 (0 wraps to 31).
  - order 3: lfsr <= {lfsr[3:0], lfsr[4]^lfsr[2]}. Period 31; address 0 is never produced after the seed.
- count > 32 wraps and re-reads locations; this is legal.
- Timing with out_ready held high:
  - First word valid after edge E1.
  - One word per cycle.
  - Last word valid after edge E_count.
  - done high after edge E_count+1.
  - Total latency, start to done: count+1 cycles.
- The register contents are read as-is. No arithmetic is performed; rezultat is passed through unchanged at 64 bits.

Test Plan:
- Increasing wrap: first_addr=0, count=4, order=1, ready=1 -> out_addr 0,1,2,3 on consecutive cycles; out_word matches register contents; done 5 cycles after start; words_sent=4.
- Decreasing wrap: first_addr=1, count=3, order=2 -> out_addr 1,0,31; done pulses once; busy low afterwards.
- Backpressure: count=3, order=1, out_ready low for 3 cycles after first valid -> out_addr/out_word stable during stall; read_pointer held; all 3 words delivered exactly once in order.
- LFSR: first_addr=0, count=6, order=3 -> out_addr 1,2,4,9,18,5.
- Ignored requests: start with count=0 -> busy stays 0, no out_valid. start pulsed during RUN -> current burst unaffected, count unchanged.
- Reset mid-burst: count=10, assert reset_n=0 after 4th word -> all outputs at reset values in the same cycle, no done. A new start afterwards runs a full burst from first_addr.
